// File: rtl/move_sequencer.sv
// Move sequencer: runs calc_times for one accepted move command, finds the axis with the longest
// total time and hands the result to the step executor through a one-slot register.
// Optional move counter on mv_count: define MOVE_SEQ_COUNT_EN.
module move_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CMP_LAST       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_params_x  [0:4],
  input  logic [31:0] cmd_params_y  [0:4],
  input  logic [31:0] cmd_params_z  [0:4],
  input  logic [31:0] cmd_params_e0 [0:4],
  input  logic [31:0] cmd_params_e1 [0:4],
  output logic        ct_start,
  output logic [31:0] ct_params_x   [0:4],
  output logic [31:0] ct_params_y   [0:4],
  output logic [31:0] ct_params_z   [0:4],
  output logic [31:0] ct_params_e0  [0:4],
  output logic [31:0] ct_params_e1  [0:4],
  input  logic [63:0] ct_timing_x   [0:3],
  input  logic [63:0] ct_timing_y   [0:3],
  input  logic [63:0] ct_timing_z   [0:3],
  input  logic [63:0] ct_timing_e0  [0:3],
  input  logic [63:0] ct_timing_e1  [0:3],
  input  logic        ct_finish,
  output logic        mv_valid,
  input  logic        mv_ready,
  output logic [63:0] mv_timing_x   [0:3],
  output logic [63:0] mv_timing_y   [0:3],
  output logic [63:0] mv_timing_z   [0:3],
  output logic [63:0] mv_timing_e0  [0:3],
  output logic [63:0] mv_timing_e1  [0:3],
  output logic [63:0] mv_total,
  output logic [2:0]  mv_lead,
  output logic        busy,
  input  logic        err_clr,
  output logic        err_timeout,
  output logic [31:0] mv_count
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and the offered data is stable until the transfer.

  typedef enum logic [2:0] {IDLE, LOAD, CALC, CMP, DONE, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] calc_cnt;
  logic [2:0]  cmp_idx;
  logic [63:0] run_max;
  logic [2:0]  run_lead;
  logic [63:0] tim_in [0:4][0:3];
  logic [63:0] cap    [0:4][0:3];
  logic [63:0] slot   [0:4][0:3];
  logic        calc_to, slot_free, cmp_gt;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      tim_in[0][j]    = ct_timing_x[j];
      tim_in[1][j]    = ct_timing_y[j];
      tim_in[2][j]    = ct_timing_z[j];
      tim_in[3][j]    = ct_timing_e0[j];
      tim_in[4][j]    = ct_timing_e1[j];
      mv_timing_x[j]  = slot[0][j];
      mv_timing_y[j]  = slot[1][j];
      mv_timing_z[j]  = slot[2][j];
      mv_timing_e0[j] = slot[3][j];
      mv_timing_e1[j] = slot[4][j];
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign calc_to   = (state == CALC) && !ct_finish && (calc_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign slot_free = !mv_valid || mv_ready;
  // Strictly greater keeps the lowest axis index on ties.
  assign cmp_gt    = cap[cmp_idx][3] > run_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid) state_nx = LOAD;
      LOAD:    state_nx = CALC;
      CALC:    if (ct_finish) state_nx = CMP;
               else if (calc_to) state_nx = DRAIN;
      CMP:     if (cmp_idx == 3'(CMP_LAST)) state_nx = DONE;
      DONE:    if (slot_free) state_nx = ct_finish ? DRAIN : IDLE;
      DRAIN:   if (!ct_finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ct_start    <= 1'b0;
      calc_cnt    <= '0;
      cmp_idx     <= '0;
      run_max     <= '0;
      run_lead    <= '0;
      mv_valid    <= 1'b0;
      mv_total    <= '0;
      mv_lead     <= '0;
      err_timeout <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        ct_params_x[i]  <= '0;
        ct_params_y[i]  <= '0;
        ct_params_z[i]  <= '0;
        ct_params_e0[i] <= '0;
        ct_params_e1[i] <= '0;
      end
      for (int a = 0; a < 5; a++)
        for (int j = 0; j < 4; j++) begin
          cap[a][j]  <= '0;
          slot[a][j] <= '0;
        end
    end else begin
      // Start is a level held exactly while the FSM sits in CALC.
      ct_start <= (state_nx == CALC);

      if (state == IDLE && cmd_valid) begin
        ct_params_x  <= cmd_params_x;
        ct_params_y  <= cmd_params_y;
        ct_params_z  <= cmd_params_z;
        ct_params_e0 <= cmd_params_e0;
        ct_params_e1 <= cmd_params_e1;
      end

      if (state == LOAD) calc_cnt <= '0;
      else if (state == CALC) calc_cnt <= calc_cnt + 32'd1;

      if (state == CALC && ct_finish) begin
        cap      <= tim_in;
        cmp_idx  <= '0;
        run_max  <= '0;
        run_lead <= '0;
      end

      if (state == CMP) begin
        cmp_idx <= cmp_idx + 3'd1;
        if (cmp_gt) begin
          run_max  <= cap[cmp_idx][3];
          run_lead <= cmp_idx;
        end
      end

      // A reload in the same cycle as a consume keeps mv_valid high with the new move.
      if (state == DONE && slot_free) begin
        mv_valid <= 1'b1;
        slot     <= cap;
        mv_total <= run_max;
        mv_lead  <= run_lead;
      end else if (mv_ready) begin
        mv_valid <= 1'b0;
      end

      if (calc_to) err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

`ifdef MOVE_SEQ_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mv_count <= '0;
    else if (state == DONE && slot_free) mv_count <= mv_count + 32'd1;
  end
`else
  assign mv_count = '0;
`endif

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Sequences the calc_times profile calculator for the motion path. Accepts one move command (5 params per axis) via valid/ready and drives calc_times start/finish. Captures the four timings per axis, finds the longest total time (the axis that sets move duration) and presents the result in a one-slot output register to the step executor. The next move is calculated while the executor still holds the previous one.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles in CALC waiting for ct_finish before abort (>=1)
CMP_LAST, 4, index of last axis compared (0=X,1=Y,2=Z,3=E0,4=E1); fixed for 5 axes

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
cmd_valid  in  1  move command present
cmd_ready  out  1  sequencer accepts command
cmd_params_x/_y/_z/_e0/_e1  in  32 x[0:4] each  per-axis move params, same layout as calc_times params
ct_start  out  1  to calc_times start; level, held until finish
ct_params_x/_y/_z/_e0/_e1  out  32 x[0:4] each  registered copy of accepted params
ct_timing_x/_y/_z/_e0/_e1  in  64 x[0:3] each  calc_times results [t1,t2,t3,tt]
ct_finish  in  1  calc_times done; stays high while start high
mv_valid  out  1  output slot holds a move
mv_ready  in  1  executor consumes slot
mv_timing_x/_y/_z/_e0/_e1  out  64 x[0:3] each  captured timings of the move in slot
mv_total  out  64  max tt over all axes
mv_lead  out  3  index of axis giving mv_total
busy  out  1  state != IDLE
err_clr  in  1  clears err_timeout
err_timeout  out  1  sticky abort flag
mv_count  out  32  moves emitted (optional feature)

Behaviour:
- Reset (async): state IDLE; all outputs, ct_params, capture regs, output slot = 0; ct_start drops immediately; in-flight command discarded.
- States: IDLE, LOAD, CALC, CMP, DONE, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid: latch params into ct_params -> LOAD.
- LOAD: one cycle -> CALC. ct_start is registered and goes high on entry to CALC, one cycle after acceptance.
- CALC: ct_start=1; cycle counter increments. On ct_finish=1: capture all ct_timing into internal regs, ct_start=0 -> CMP. If counter reaches TIMEOUT_CYCLES first: ct_start=0, err_timeout=1, command dropped, nothing emitted -> DRAIN.
- CMP: 5 cycles, one axis per cycle, X first. Running max of tt, unsigned 64-bit. Strictly-greater replaces, so on ties the lowest index wins. All tt=0 gives total 0, lead 0, move still emitted -> DONE.
- DONE: wait until slot free (mv_valid=0, or mv_valid&mv_ready this cycle). Then load slot and set mv_valid=1 next edge -> IDLE if ct_finish=0, else DRAIN.
- DRAIN: wait ct_finish=0 -> IDLE.
- Minimum latency: ct_finish sampled at edge N -> mv_valid high at edge N+6.
- Output slot: mv_valid clears on mv_valid&mv_ready unless DONE reloads in the same cycle, in which case it stays high with new data. Slot contents are stable while mv_valid=1 and mv_ready=0.
- err_timeout: set has priority over simultaneous err_clr. It does not block new commands.
- cmd_ready=0 in every state except IDLE, so at most one move is being calculated plus one held.

Optional Feature:
MOVE_SEQ_COUNT_EN: when defined, mv_count increments on each slot load (DONE transfer) and wraps at 2^32; reset to 0 only by reset. When undefined, mv_count is tied to 0 and no counter logic is built.

Test Plan:
- Stub calc_times finishes 20 cycles after start with tt X=100, Y=250, Z=250, E0=40, E1=0 -> mv_total=250, mv_lead=1, mv_timing matches stub; mv_valid rises 6 edges after finish sampled.
- Same stub, all tt=0 -> mv_valid=1, mv_total=0, mv_lead=0.
- TIMEOUT_CYCLES=16, stub never finishes -> ct_start low after 16 CALC cycles, err_timeout=1, no mv_valid, cmd_ready=1 once back in IDLE. Pulse err_clr -> err_timeout=0.
- mv_ready=0, two commands with E0 tt=500 then X tt=900 -> first in slot, second waits in DONE with cmd_ready=0. Pulse mv_ready for one cycle -> next edge slot holds total=900, lead=0, mv_valid stays 1.
- Assert reset 5 cycles into CALC -> ct_start, busy, mv_valid drop without a clock edge. After release, a fresh command completes normally.
- MOVE_SEQ_COUNT_EN defined, 3 moves emitted -> mv_count=3. Undefined -> mv_count=0.
